// File: rtl/hamming_secded_codec.sv
// -----------------------------------------------------------------------------
// hamming_secded_codec
//
// Extended-Hamming SECDED encoder/decoder behind a 2-stage valid/ready pipeline.
// Each accepted beat is an encode (in_mode=0) or a decode (in_mode=1).
//
// Codeword layout (CW_WIDTH = DATA_WIDTH + P + 1):
//   bit 0        : overall even parity over bits 1..CW_WIDTH-1
//   bit 2^i      : Hamming parity i, covering every position j with j & 2^i
//   other bits   : data in ascending order (data[0] at position 3)
//
// Optional build macro ECC_ERR_INJECT_EN adds inj_mask, which is XORed into
// the generated codeword of each accepted encode beat (ignored for decode).
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_mode             0 = encode, 1 = decode
//   in_data             payload to encode
//   in_codeword         received codeword to decode
//   inj_mask            (ECC_ERR_INJECT_EN only) encode fault-insertion mask
//   out_valid/out_ready output handshake
//   out_mode            mode of the transaction presented
//   out_data            encode: echo of in_data; decode: corrected data
//   out_codeword        encode: generated codeword; decode: corrected codeword
//   out_single_err      decode: single error corrected
//   out_double_err      decode: uncorrectable error detected
//   out_syndrome        decode: Hamming syndrome (0 on encode)
//   cnt_clear           synchronous clear of both statistics counters
//   cnt_corrected       saturating count of single-error results handed off
//   cnt_uncorrectable   saturating count of double-error results handed off
// -----------------------------------------------------------------------------
module hamming_secded_codec #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  // Smallest P with 2^P >= DATA_WIDTH + P + 1, for DATA_WIDTH in 4..64.
  localparam int P        = (DATA_WIDTH <= 4)  ? 3 :
                            (DATA_WIDTH <= 11) ? 4 :
                            (DATA_WIDTH <= 26) ? 5 :
                            (DATA_WIDTH <= 57) ? 6 : 7,
  localparam int CW_WIDTH = DATA_WIDTH + P + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CW_WIDTH-1:0]   in_codeword,
`ifdef ECC_ERR_INJECT_EN
  input  logic [CW_WIDTH-1:0]   inj_mask,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mode,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW_WIDTH-1:0]   out_codeword,
  output logic                  out_single_err,
  output logic                  out_double_err,
  output logic [P-1:0]          out_syndrome,
  input  logic                  cnt_clear,
  output logic [CNT_WIDTH-1:0]  cnt_corrected,
  output logic [CNT_WIDTH-1:0]  cnt_uncorrectable
);

  localparam logic [CW_WIDTH-1:0]  ONE_CW   = CW_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);
  localparam logic [P:0]           LAST_POS = (P+1)'(CW_WIDTH - 1);

  // Positions 1..CW_WIDTH-1 whose index has bit b set (bit 0 never included).
  function automatic logic [CW_WIDTH-1:0] cover_mask(input int b);
    logic [CW_WIDTH-1:0] m;
    m = '0;
    for (int j = 1; j < CW_WIDTH; j++) begin
      if (((j >> b) & 1) != 0) m = m | (ONE_CW << j);
    end
    return m;
  endfunction

  // Handshake: a beat moves on an interface when valid && ready in the same
  // cycle. valid never depends on ready; a stage may load whenever it is empty
  // or its content is leaving this cycle, so ready only looks downstream.
  logic adv1, adv2;

  // Stage 1 registers.
  logic                  v1_q;
  logic                  mode1_q;
  logic [DATA_WIDTH-1:0] data1_q;
  logic [CW_WIDTH-1:0]   cw1_q;
  logic [P-1:0]          syn1_q;
  logic                  op1_q;

  // Stage 2 (output) registers.
  logic                  v2_q;
  logic                  mode2_q;
  logic [DATA_WIDTH-1:0] data2_q;
  logic [CW_WIDTH-1:0]   cw2_q;
  logic                  se2_q;
  logic                  de2_q;
  logic [P-1:0]          syn2_q;

  logic [CNT_WIDTH-1:0]  cnt_c_q;
  logic [CNT_WIDTH-1:0]  cnt_u_q;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: encoder and syndrome/overall-parity of the input.
  // ---------------------------------------------------------------------------
  logic [CW_WIDTH-1:0] enc_dat;   // data scattered into its positions
  logic [CW_WIDTH-1:0] enc_body;  // data plus Hamming parities, bit 0 zero
  logic [CW_WIDTH-1:0] enc_cw;
  logic [CW_WIDTH-1:0] enc_tx;
  logic [P-1:0]        rx_syn;
  logic                rx_op;
  logic [CW_WIDTH-1:0] cw1_d;
  logic [P-1:0]        syn1_d;
  logic                op1_d;

  for (genvar j = 0; j < CW_WIDTH; j++) begin : g_enc
    if ((j & (j - 1)) == 0) begin : g_par
      // Position 0 and powers of two carry parity, not data.
      assign enc_dat[j] = 1'b0;
      if (j == 0) begin : g_zero
        assign enc_body[j] = 1'b0;
      end else begin : g_ham
        assign enc_body[j] = ^(enc_dat & cover_mask($clog2(j)));
      end
    end else begin : g_dat
      // Data index = position minus the parity slots at or below it.
      assign enc_dat[j]  = in_data[j - $clog2(j + 1) - 1];
      assign enc_body[j] = enc_dat[j];
    end
  end

  assign enc_cw = {enc_body[CW_WIDTH-1:1], ^enc_body[CW_WIDTH-1:1]};

`ifdef ECC_ERR_INJECT_EN
  assign enc_tx = enc_cw ^ inj_mask;
`else
  assign enc_tx = enc_cw;
`endif

  for (genvar b = 0; b < P; b++) begin : g_syn
    assign rx_syn[b] = ^(in_codeword & cover_mask(b));
  end
  assign rx_op = ^in_codeword;

  assign cw1_d  = in_mode ? in_codeword : enc_tx;
  assign syn1_d = in_mode ? rx_syn : '0;
  assign op1_d  = in_mode & rx_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      mode1_q <= 1'b0;
      data1_q <= '0;
      cw1_q   <= '0;
      syn1_q  <= '0;
      op1_q   <= 1'b0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        mode1_q <= in_mode;
        data1_q <= in_mode ? '0 : in_data;
        cw1_q   <= cw1_d;
        syn1_q  <= syn1_d;
        op1_q   <= op1_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: classify and correct.
  // ---------------------------------------------------------------------------
  logic                  se2_d;
  logic                  de2_d;
  logic [CW_WIDTH-1:0]   flip;
  logic [CW_WIDTH-1:0]   cw2_d;
  logic [DATA_WIDTH-1:0] dec_data;
  logic [DATA_WIDTH-1:0] data2_d;

  always_comb begin
    se2_d = 1'b0;
    de2_d = 1'b0;
    flip  = '0;
    if (mode1_q) begin
      // Odd overall parity with a syndrome that names a real position (or 0,
      // meaning bit 0 itself) is one flipped bit. Anything else non-clean is
      // uncorrectable and passes through untouched.
      if (op1_q && ({1'b0, syn1_q} <= LAST_POS)) begin
        se2_d = 1'b1;
        flip  = ONE_CW << syn1_q;
      end else if (syn1_q != '0) begin
        de2_d = 1'b1;
      end
    end
  end

  assign cw2_d = cw1_q ^ flip;

  for (genvar j = 3; j < CW_WIDTH; j++) begin : g_ext
    if ((j & (j - 1)) != 0) begin : g_dat
      assign dec_data[j - $clog2(j + 1) - 1] = cw2_d[j];
    end
  end

  assign data2_d = mode1_q ? dec_data : data1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      mode2_q <= 1'b0;
      data2_q <= '0;
      cw2_q   <= '0;
      se2_q   <= 1'b0;
      de2_q   <= 1'b0;
      syn2_q  <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        mode2_q <= mode1_q;
        data2_q <= data2_d;
        cw2_q   <= cw2_d;
        se2_q   <= se2_d;
        de2_q   <= de2_d;
        syn2_q  <= syn1_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics: count results as they are handed off, saturating; clear wins.
  // ---------------------------------------------------------------------------
  logic out_hs;
  assign out_hs = v2_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_c_q <= '0;
      cnt_u_q <= '0;
    end else if (cnt_clear) begin
      cnt_c_q <= '0;
      cnt_u_q <= '0;
    end else begin
      if (out_hs && se2_q && (cnt_c_q != '1)) cnt_c_q <= cnt_c_q + ONE_CNT;
      if (out_hs && de2_q && (cnt_u_q != '1)) cnt_u_q <= cnt_u_q + ONE_CNT;
    end
  end

  assign out_valid         = v2_q;
  assign out_mode          = mode2_q;
  assign out_data          = data2_q;
  assign out_codeword      = cw2_q;
  assign out_single_err    = se2_q;
  assign out_double_err    = de2_q;
  assign out_syndrome      = syn2_q;
  assign cnt_corrected     = cnt_c_q;
  assign cnt_uncorrectable = cnt_u_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_codec
//
// Bench for hamming_secded_codec at DATA_WIDTH=8 (CW_WIDTH=13), CNT_WIDTH=2.
// Expected results come from a position-arithmetic model of the code; a
// monitor compares every presented output against the head of exp_q and
// tracks the statistics counters.
// -----------------------------------------------------------------------------
module tb_hamming_secded_codec;

  localparam int DW   = 8;
  localparam int CNTW = 2;
  localparam int P    = 4;
  localparam int CW   = DW + P + 1;
  localparam int EW   = 1 + DW + CW + 1 + 1 + P;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            in_valid, in_ready, in_mode;
  logic [DW-1:0]   in_data;
  logic [CW-1:0]   in_codeword;
  logic            out_valid, out_ready, out_mode;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_codeword;
  logic            out_single_err, out_double_err;
  logic [P-1:0]    out_syndrome;
  logic            cnt_clear;
  logic [CNTW-1:0] cnt_corrected, cnt_uncorrectable;
`ifdef ECC_ERR_INJECT_EN
  logic [CW-1:0]   inj_mask;
`endif

  hamming_secded_codec #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_mode           (in_mode),
    .in_data           (in_data),
    .in_codeword       (in_codeword),
`ifdef ECC_ERR_INJECT_EN
    .inj_mask          (inj_mask),
`endif
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_mode          (out_mode),
    .out_data          (out_data),
    .out_codeword      (out_codeword),
    .out_single_err    (out_single_err),
    .out_double_err    (out_double_err),
    .out_syndrome      (out_syndrome),
    .cnt_clear         (cnt_clear),
    .cnt_corrected     (cnt_corrected),
    .cnt_uncorrectable (cnt_uncorrectable)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]   exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  logic [CNTW-1:0] m_corr = '0;
  logic [CNTW-1:0] m_unc  = '0;
  logic            rand_bp = 1'b0;

  // Last handed-off DUT result, for directed checks against hand values.
  logic [DW-1:0]   last_data;
  logic [CW-1:0]   last_cw;
  logic            last_se, last_de;
  logic [P-1:0]    last_syn;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  // Encode: scatter data into non-power-of-two positions, XOR together the
  // indices of all set data positions; that XOR is exactly the parity pattern.
  function automatic logic [CW-1:0] model_encode(input logic [DW-1:0] d);
    logic [CW-1:0] cw;
    int k, s;
    cw = '0; k = 0; s = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (!is_pow2(pos)) begin
        if (d[k]) begin
          cw[pos] = 1'b1;
          s = s ^ pos;
        end
        k++;
      end
    end
    for (int b = 0; b < P; b++) if (((s >> b) & 1) == 1) cw[1 << b] = 1'b1;
    cw[0] = ($countones(cw) % 2) == 1;
    return cw;
  endfunction

  function automatic logic [DW-1:0] model_extract(input logic [CW-1:0] cw);
    logic [DW-1:0] d;
    int k;
    d = '0; k = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (!is_pow2(pos)) begin
        d[k] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [EW-1:0] model_decode(input logic [CW-1:0] cw);
    int s;
    bit op, se, de;
    logic [CW-1:0] corr;
    logic [P-1:0] syn;
    s = 0;
    for (int pos = 1; pos < CW; pos++) if (cw[pos]) s = s ^ pos;
    op = ($countones(cw) % 2) == 1;
    se = 0; de = 0; corr = cw;
    if (op && s < CW) begin
      se = 1;
      corr[s] = ~corr[s];
    end else if (s != 0) begin
      de = 1;
    end
    syn = P'(s);
    return {1'b1, model_extract(corr), corr, se, de, syn};
  endfunction

  function automatic logic [EW-1:0] model_item(input logic mode, input logic [DW-1:0] d,
                                               input logic [CW-1:0] cw, input logic [CW-1:0] mask);
    logic [CW-1:0] enc;
    if (mode) return model_decode(cw);
    enc = model_encode(d);
`ifdef ECC_ERR_INJECT_EN
    enc = enc ^ mask;
`else
    if (mask != '0) enc = enc;
`endif
    return {1'b0, d, enc, 1'b0, 1'b0, {P{1'b0}}};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic mode, input logic [DW-1:0] d,
                      input logic [CW-1:0] cw, input logic [CW-1:0] mask);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_mode = mode; in_data = d; in_codeword = cw;
`ifdef ECC_ERR_INJECT_EN
    inj_mask = mask;
`endif
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      exp_q.push_back(model_item(mode, d, cw, mask));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [EW-1:0] exp_item, got;
    logic hs, exp_se, exp_de;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_corr = '0;
        m_unc  = '0;
      end else begin
        check("cnt_corrected", 32'(cnt_corrected), 32'(m_corr));
        check("cnt_uncorrectable", 32'(cnt_uncorrectable), 32'(m_unc));
        hs = out_valid && out_ready;
        exp_se = 1'b0; exp_de = 1'b0;
        if (out_valid) begin
          got = {out_mode, out_data, out_codeword, out_single_err, out_double_err, out_syndrome};
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: got 0x%0h, required no output at %0t", got, $time);
          end else begin
            exp_item = exp_q[0];
            check("result", 32'(got), 32'(exp_item));
            if (hs) begin
              void'(exp_q.pop_front());
              exp_se    = exp_item[P+1];
              exp_de    = exp_item[P];
              last_syn  = got[P-1:0];
              last_de   = got[P];
              last_se   = got[P+1];
              last_cw   = got[P+2 +: CW];
              last_data = got[P+2+CW +: DW];
            end
          end
        end
        if (cnt_clear) begin
          m_corr = '0;
          m_unc  = '0;
        end else begin
          if (hs && exp_se && m_corr != '1) m_corr = m_corr + 1'b1;
          if (hs && exp_de && m_unc  != '1) m_unc  = m_unc + 1'b1;
        end
      end
    end
  end

  // Random backpressure and occasional counter clears during the random phase.
  initial begin : bp_gen
    forever begin
      @(posedge clk); #1;
      if (rand_bp) begin
        out_ready = ($urandom_range(0, 3) != 0);
        cnt_clear = ($urandom_range(0, 63) == 0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    n_vec++; n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- main stimulus ----------------
  localparam logic [CW-1:0] CW_A5 = 13'h144E;  // encode(0xA5), worked by hand

  initial begin : main
    logic [DW-1:0] d;
    logic [CW-1:0] cw, mask;
    logic [DW-1:0] bp_d[4];
    int acc, bi, kind, a, b, seen;

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_codeword = '0;
    out_ready = 1'b1; cnt_clear = 1'b0;
`ifdef ECC_ERR_INJECT_EN
    inj_mask = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_codeword", 32'(out_codeword), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_flags_syn", 32'({out_single_err, out_double_err, out_syndrome}), 0);
    check("reset_counters", 32'({cnt_corrected, cnt_uncorrectable}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Encode 0xA5 and check latency.
    send(1'b0, 8'hA5, '0, '0);
    check("latency_not_early", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("latency_valid", 32'(out_valid), 1);
    check("encode_a5_codeword", 32'(out_codeword), 32'(CW_A5));
    drain();

    // Clean decode.
    send(1'b1, '0, CW_A5, '0);
    drain();
    check("clean_data", 32'(last_data), 32'h A5);
    check("clean_flags_syn", 32'({last_se, last_de, last_syn}), 0);

    // Single error at bit 6.
    send(1'b1, '0, CW_A5 ^ 13'h0040, '0);
    drain();
    check("single6_data", 32'(last_data), 32'h A5);
    check("single6_se", 32'(last_se), 1);
    check("single6_syn", 32'(last_syn), 6);
    check("single6_cnt", 32'(cnt_corrected), 1);

    // Single error in the overall parity bit.
    send(1'b1, '0, CW_A5 ^ 13'h0001, '0);
    drain();
    check("single0_se", 32'(last_se), 1);
    check("single0_syn", 32'(last_syn), 0);
    check("single0_cw", 32'(last_cw), 32'(CW_A5));

    // Double error at bits 3 and 5.
    send(1'b1, '0, CW_A5 ^ 13'h0028, '0);
    drain();
    check("double_de", 32'(last_de), 1);
    check("double_se", 32'(last_se), 0);
    check("double_syn", 32'(last_syn), 6);
    check("double_cw_unchanged", 32'(last_cw), 32'(CW_A5 ^ 13'h0028));
    check("double_cnt", 32'(cnt_uncorrectable), 1);

    // Backpressure: 4 beats offered over 5 stalled cycles.
    for (int i = 0; i < 4; i++) bp_d[i] = DW'($urandom);
    out_ready = 1'b0; acc = 0; bi = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (bi < 4);
      in_mode  = 1'b0;
      in_data  = bp_d[bi % 4];
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model_item(1'b0, bp_d[bi], '0, '0));
        bi++; acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 2);
    check("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    while (bi < 4) begin
      send(1'b0, bp_d[bi], '0, '0);
      bi++;
    end
    drain();

    // Counter clear, saturation, and clear beating a same-cycle increment.
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    check("clear_counters", 32'({cnt_corrected, cnt_uncorrectable}), 0);
    for (int i = 0; i < 4; i++) begin
      d = DW'($urandom);
      send(1'b1, '0, model_encode(d) ^ (CW'(1) << $urandom_range(0, CW - 1)), '0);
    end
    drain();
    check("sat_corrected", 32'(cnt_corrected), 3);
    out_ready = 1'b0;
    send(1'b1, '0, model_encode(8'h3C) ^ 13'h0100, '0);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    cnt_clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    check("clear_priority", 32'(cnt_corrected), 0);
    drain();

    // Random traffic with random backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      d = DW'($urandom);
      mask = '0;
`ifdef ECC_ERR_INJECT_EN
      if ($urandom_range(0, 3) == 0) mask = CW'(1) << $urandom_range(0, CW - 1);
`endif
      if ($urandom_range(0, 2) == 0) begin
        send(1'b0, d, CW'($urandom), mask);
      end else begin
        cw = model_encode(d);
        kind = $urandom_range(0, 3);
        a = $urandom_range(0, CW - 1);
        b = (a + $urandom_range(1, CW - 1)) % CW;
        if (kind >= 1) cw = cw ^ (CW'(1) << a);
        if (kind == 2) cw = cw ^ (CW'(1) << b);
        if (kind == 3) cw = CW'($urandom);
        send(1'b1, DW'($urandom), cw, mask);
      end
    end
    rand_bp = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    drain();

    // Async reset with two beats in flight.
    send(1'b1, '0, CW_A5 ^ 13'h0010, '0);
    drain();
    out_ready = 1'b0;
    send(1'b0, 8'h11, '0, '0);
    send(1'b0, 8'h22, '0, '0);
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", 32'(out_valid), 0);
    check("areset_counters", 32'({cnt_corrected, cnt_uncorrectable}), 0);
    check("areset_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_output", 32'(seen), 0);
    @(posedge clk); #1;
    send(1'b0, 8'h5A, '0, '0);
    drain();

    check("queue_empty_at_end", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
